decode_issue: RTL
=================

# decode_issue

Decode-and-issue stage feeding the execute-stage ALU. Accepts one 32-bit RV64 instruction per cycle from fetch over a valid/ready handshake, decodes the integer ALU subset into an `alufunc_t` opcode, reads the register file, and selects operands. It holds the result in an output pipeline register handed to execute over valid/ready. An optional scoreboard stalls issue on read-after-write hazards until writeback clears them.

## Interface
Parameters:
- `XLEN`, 64, datapath width.
- `NREG`, 32, architectural registers; x0 hardwired zero.

Ports (one clock; reset is asynchronous and active-low, named as the codebase does):
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `if_valid`  in  1  fetch offers an instruction
- `if_ready`  out  1  stage accepts this cycle
- `if_inst`  in  32  instruction word
- `if_pc`  in  64  instruction PC
- `ra1`, `ra2`  out  5  register-file read addresses, combinational from `if_inst[19:15]`, `[24:20]`
- `rd1`, `rd2`  in  64  register-file read data, same cycle
- `wb_valid`  in  1  writeback retires a register write
- `wb_rd`  in  5  writeback destination
- `flush`  in  1  squash the output register and block acceptance this cycle
- `ex_valid`  out  1  output register holds an instruction
- `ex_ready`  in  1  execute consumes it
- `ex_pc`  out  64  PC
- `ex_src1`, `ex_src2`  out  64  ALU operands
- `ex_aluop`  out  `alufunc_t`  ALU operation
- `ex_rd`  out  5  destination
- `ex_wen`  out  1  writes `ex_rd`
- `ex_illegal`  out  1  unsupported encoding

## Operation
- Decoding by opcode:
  - 0110011 funct3/funct7: add/sub/and/or/xor map to ALU_ADD/SUB/AND/OR/XOR; src2 = `rd2`.
  - 0010011 addi/xori/ori/andi map to ADD/XOR/OR/AND; src2 = sign-extended `inst[31:20]`.
  - 0011011 funct3=000 maps to ALU_ADDIW; src2 = immediate.
  - 0111011 addw/subw map to ALU_ADDW/ALU_SUBW; src2 = `rd2`.
  - src1 = `rd1` in every case.
- Any other encoding: `ex_illegal`=1, `ex_wen`=0, `ex_aluop`=ALU_ADD, sources 0.
- `ex_wen` = legal && rd≠0.
- Load condition: `load = !ex_valid || ex_ready`. `if_ready = load && !stall && !flush`. A transfer occurs when `if_valid && if_ready`.
- The output register loads on transfer. On `ex_ready` without a transfer, `ex_valid` drops to 0. With `load`=0, all `ex_*` outputs hold their values.
- Scoreboard: 32 busy bits; x0 is never busy.
  - `stall` = busy[rs1], or busy[rs2] for R-type instructions.
  - A transfer with `ex_wen` sets busy[rd]. `wb_valid` clears busy[wb_rd].
  - Set and clear of the same register in one cycle: set wins.
- Flush: `ex_valid`←0 next cycle. If the squashed entry had `ex_wen`, its busy bit clears, unless a concurrent set targets it. Other busy bits are unaffected.

## Timing
- Reset values: `ex_valid`=0, `ex_pc`=0, `ex_src*`=0, `ex_aluop`=ALU_ADD, `ex_rd`=0, `ex_wen`=0, `ex_illegal`=0, all busy bits 0. Reset mid-operation discards the in-flight entry.
- Latency is one cycle from transfer to `ex_valid`. Throughput is 1/cycle with `ex_ready` held high.
- `if_ready` is combinational from `ex_valid`, `ex_ready`, busy state, `if_inst` and `flush`.
- Hazards:
  - Back-to-back dependent instructions stall until the cycle after the `wb_valid` that clears the register; busy is registered, with no same-cycle bypass.
  - A `wb_valid` to a non-busy register is ignored.

## Configuration
- `DECODE_SCOREBOARD_EN` defined: busy bits and stall logic as above.
- `DECODE_SCOREBOARD_EN` undefined: no busy state, `stall`≡0, and `wb_valid`/`wb_rd` are ignored. Hazard avoidance is left to software.

## Structure
- Shared package `pipes`:
  - `alufunc_t` (already holds ALU_ADD…ALU_ADDIW).
  - Opcode constants OP_R=7'b0110011, OP_I, OP_IW, OP_RW.
  - An `issue_t` struct bundling the `ex_*` fields.
- Package `common`: `u64`/`u32`.
- One sub-module, `scoreboard`: busy bits, set/clear, and the stall query.

## Test plan
- Reset → `ex_valid`=0, `ex_aluop`=ALU_ADD. Release, then `addi x1,x0,5` (0x00500093) with `rd1`=0 → next cycle `ex_src1`=0, `ex_src2`=5, ALU_ADD, `ex_rd`=1, `ex_wen`=1.
- `addiw` with imm -1 (`inst[31:20]`=0xFFF) → `ex_src2`=0xFFFF_FFFF_FFFF_FFFF, ALU_ADDIW. `sub x3,x1,x2` → ALU_SUB, `ex_src2`=`rd2`.
- `addi x1`, then `add x2,x1,x1` → `if_ready`=0 until busy[1] clears. Pulse `wb_valid`, `wb_rd`=1 → `if_ready`=1 next cycle, and `add` issues. With macro undefined → no stall.
- `ex_ready`=0 for 3 cycles with `if_valid`=1 → outputs stable, `if_ready`=0. Raise `ex_ready` → new instruction loads the same edge.
- Opcode 0x0000007F → `ex_illegal`=1, `ex_wen`=0. `add x0,x1,x2` → `ex_wen`=0, busy unchanged.
- `flush` while holding `addi x4` → `ex_valid`=0 next cycle, busy[4]=0. Simultaneous `wb_valid` to x5 plus issue to x5 → busy[5]=1.

Source files
------------

// File: rtl/decode_issue_pkg.sv
// Shared types for the decode/issue slice: scalar aliases (common) and
// pipeline-level ALU opcodes, opcode constants and the issue bundle (pipes).
package common;
  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
endpackage

package pipes;
  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_ADDW,
    ALU_SUBW,
    ALU_ADDIW
  } alufunc_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_IW = 7'b0011011;
  localparam logic [6:0] OP_RW = 7'b0111011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Everything the execute stage receives for one instruction.
  typedef struct packed {
    common::u64 pc;
    common::u64 src1;
    common::u64 src2;
    alufunc_t   aluop;
    logic [4:0] rd;
    logic       wen;
    logic       illegal;
  } issue_t;

  // Register-register forms are the only ones whose rs2 field names a source.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_R) || (opcode == OP_RW);
  endfunction
endpackage

// File: rtl/decode_issue_if.sv
// Issue-to-execute handshake: decode is the master (drives valid + payload),
// execute is the slave (drives ready).
interface decode_issue_if #(parameter int XLEN = 64);
  import pipes::*;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_src1;
  logic [XLEN-1:0] ex_src2;
  alufunc_t        ex_aluop;
  logic [4:0]      ex_rd;
  logic            ex_wen;
  logic            ex_illegal;

  modport master (
    output ex_valid, ex_pc, ex_src1, ex_src2, ex_aluop, ex_rd, ex_wen, ex_illegal,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_pc, ex_src1, ex_src2, ex_aluop, ex_rd, ex_wen, ex_illegal,
    output ex_ready
  );
endinterface

// File: rtl/decode_issue_scoreboard.sv
// Busy-bit scoreboard for read-after-write hazards.
// Compiled in only when DECODE_SCOREBOARD_EN is defined; otherwise stall is
// tied low and every input is ignored.
module decode_issue_scoreboard #(
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [$clog2(NREG)-1:0] rs1,
  input  logic [$clog2(NREG)-1:0] rs2,
  input  logic                    use_rs2,
  input  logic                    set_en,
  input  logic [$clog2(NREG)-1:0] set_rd,
  input  logic                    clr_en,
  input  logic [$clog2(NREG)-1:0] clr_rd,
  input  logic                    sq_en,
  input  logic [$clog2(NREG)-1:0] sq_rd,
  output logic                    stall
);
`ifdef DECODE_SCOREBOARD_EN
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  // Clears (writeback, squash) apply first so a same-cycle issue set wins; x0 never busy.
  always_comb begin
    busy_next = busy_reg;
    if (clr_en) busy_next[clr_rd] = 1'b0;
    if (sq_en)  busy_next[sq_rd]  = 1'b0;
    if (set_en) busy_next[set_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Busy state is registered: a retirement frees the register one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_reg <= '0;
    else        busy_reg <= busy_next;
  end

  assign stall = busy_reg[rs1] || (use_rs2 && busy_reg[rs2]);
`else
  wire unused_sb = &{1'b0, clk, reset, rs1, rs2, use_rs2, set_en, set_rd,
                     clr_en, clr_rd, sq_en, sq_rd};
  assign stall = 1'b0;
`endif
endmodule

// File: rtl/decode_issue.sv
// Decode-and-issue stage: decodes the RV64 integer ALU subset, selects
// operands and holds them in an output register handed to execute.
// Optional RAW-hazard scoreboard enabled by DECODE_SCOREBOARD_EN.
module decode_issue
  import pipes::*;
#(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      ra1,
  output logic [4:0]      ra2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  decode_issue_if.master  ex
);
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic            legal;
  logic            use_imm;
  alufunc_t        op;
  issue_t          dec;
  issue_t          issue_reg;
  logic            ex_valid_reg;
  logic            load;
  logic            stall;
  logic            xfer;

  assign opcode = if_inst[6:0];
  assign funct3 = if_inst[14:12];
  assign funct7 = if_inst[31:25];
  assign imm    = {{(XLEN-12){if_inst[31]}}, if_inst[31:20]};
  assign ra1    = if_inst[19:15];
  assign ra2    = if_inst[24:20];

  // Opcode/funct decode; anything not matched stays illegal with ALU_ADD.
  always_comb begin
    legal   = 1'b0;
    use_imm = 1'b0;
    op      = ALU_ADD;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  begin legal = 1'b1; op = ALU_ADD; end
            F3_XOR:  begin legal = 1'b1; op = ALU_XOR; end
            F3_OR:   begin legal = 1'b1; op = ALU_OR;  end
            F3_AND:  begin legal = 1'b1; op = ALU_AND; end
            default: ;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          legal = 1'b1;
          op    = ALU_SUB;
        end
      end
      OP_I: begin
        use_imm = 1'b1;
        case (funct3)
          F3_ADD:  begin legal = 1'b1; op = ALU_ADD; end
          F3_XOR:  begin legal = 1'b1; op = ALU_XOR; end
          F3_OR:   begin legal = 1'b1; op = ALU_OR;  end
          F3_AND:  begin legal = 1'b1; op = ALU_AND; end
          default: ;
        endcase
      end
      OP_IW: begin
        use_imm = 1'b1;
        if (funct3 == F3_ADD) begin
          legal = 1'b1;
          op    = ALU_ADDIW;
        end
      end
      OP_RW: begin
        if (funct3 == F3_ADD && funct7 == F7_BASE) begin
          legal = 1'b1;
          op    = ALU_ADDW;
        end else if (funct3 == F3_ADD && funct7 == F7_ALT) begin
          legal = 1'b1;
          op    = ALU_SUBW;
        end
      end
      default: ;
    endcase
  end

  // Operand selection; illegal encodings carry zero sources and never write.
  always_comb begin
    dec         = '0;
    dec.pc      = if_pc;
    dec.aluop   = op;
    dec.rd      = if_inst[11:7];
    dec.illegal = !legal;
    dec.wen     = legal && (if_inst[11:7] != 5'd0);
    dec.src1    = legal ? rd1 : '0;
    dec.src2    = !legal ? '0 : (use_imm ? imm : rd2);
  end

  assign load     = !ex_valid_reg || ex.ex_ready;
  assign if_ready = load && !stall && !flush;
  assign xfer     = if_valid && if_ready;

  decode_issue_scoreboard #(.NREG(NREG)) scoreboard (
    .clk     (clk),
    .reset   (reset),
    .rs1     (if_inst[19:15]),
    .rs2     (if_inst[24:20]),
    .use_rs2 (uses_rs2(opcode)),
    .set_en  (xfer && dec.wen),
    .set_rd  (dec.rd),
    .clr_en  (wb_valid),
    .clr_rd  (wb_rd),
    .sq_en   (flush && ex_valid_reg && issue_reg.wen),
    .sq_rd   (issue_reg.rd),
    .stall   (stall)
  );

  // Output pipeline register: flush squashes, transfer loads, consume empties, else hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_reg <= 1'b0;
      issue_reg    <= '0;
    end else if (flush) begin
      ex_valid_reg <= 1'b0;
    end else if (xfer) begin
      ex_valid_reg <= 1'b1;
      issue_reg    <= dec;
    end else if (ex.ex_ready) begin
      ex_valid_reg <= 1'b0;
    end
  end

  assign ex.ex_valid   = ex_valid_reg;
  assign ex.ex_pc      = issue_reg.pc;
  assign ex.ex_src1    = issue_reg.src1;
  assign ex.ex_src2    = issue_reg.src2;
  assign ex.ex_aluop   = issue_reg.aluop;
  assign ex.ex_rd      = issue_reg.rd;
  assign ex.ex_wen     = issue_reg.wen;
  assign ex.ex_illegal = issue_reg.illegal;
endmodule
